// File: rtl/ram_latency_model.sv
// Purpose: word-addressed RAM responder with configurable access latency, request checking and read/write statistics.
// Latency: a held legal request sees LAT BUSY cycles, then one ACCESS cycle; read data is combinational in the ACCESS cycle.
// Backpressure: the requester holds ramREN/ramWEN/ramaddr stable until ACCESS; any change restarts the latency count.
module ram_latency_model #(
    parameter int LAT       = 2,
    parameter int ADDR_BITS = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [1:0]  ramstate,
    output logic [31:0] ramload,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    // ramstate encoding shared with the memory controller
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    localparam int         WORDS = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_C = 4'(LAT);

    // Transaction tracking: which request is being counted and how far along it is
    logic                 active;
    logic [3:0]           cnt;
    logic [31:0]          lat_addr;
    logic                 lat_wen;

    logic [31:0]          mem [WORDS];

    logic                 req;
    logic                 illegal;
    logic                 legal;
    logic                 same_txn;
    logic                 do_access;
    logic [ADDR_BITS-1:0] idx;

    // Classify the current request and decide whether this is the ACCESS cycle
    always_comb begin
        req       = ramREN | ramWEN;
        illegal   = req && ((ramREN && ramWEN) ||
                            (ramaddr[1:0] != 2'b00) ||
                            ((ramaddr >> (ADDR_BITS + 2)) != 32'd0));
        legal     = req && !illegal;
        // A request only continues the counted transaction if nothing about it changed
        same_txn  = active && (ramaddr == lat_addr) && (ramWEN == lat_wen);
        // A fresh request with zero latency completes in its first cycle
        do_access = !RST && legal && (same_txn ? (cnt == LAT_C) : (LAT_C == 4'd0));
        idx       = ramaddr[ADDR_BITS+1:2];
    end

    // Drive the response; read data is only presented during a read ACCESS
    always_comb begin
        ramstate = FREE;
        ramload  = 32'h0;
        if (!RST) begin
            if (illegal) begin
                ramstate = ERROR;
            end else if (legal) begin
                ramstate = do_access ? ACCESS : BUSY;
                if (do_access && !ramWEN) begin
                    ramload = mem[idx];
                end
            end
        end
    end

    // Latency counter, transaction latch and statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            active   <= 1'b0;
            cnt      <= 4'd0;
            lat_addr <= 32'h0;
            lat_wen  <= 1'b0;
            rd_count <= 32'h0;
            wr_count <= 32'h0;
        end else if (!legal) begin
            active <= 1'b0;
        end else if (do_access) begin
            // Completion ends the transaction so a held request pays full latency again
            active <= 1'b0;
            if (ramWEN) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end else if (!same_txn) begin
            // New or changed request: the old one is dropped without side effects
            lat_addr <= ramaddr;
            lat_wen  <= ramWEN;
            active   <= 1'b1;
            cnt      <= 4'd1;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    // Storage is written only on the ACCESS edge of a write; contents are never cleared
    always_ff @(posedge CLK) begin
        if (do_access && ramWEN) begin
            mem[idx] <= ramstore;
        end
    end

endmodule

// File: tb/tb_ram_latency_model.sv
module tb_ram_latency_model;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        clk;
    logic        rst;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  st  [3];
    logic [31:0] ld  [3];
    logic [31:0] rdc [3];
    logic [31:0] wrc [3];

    int checks;
    int failures;

    // Three latency flavours see identical stimulus
    ram_latency_model #(.LAT(2), .ADDR_BITS(10)) u0 (
        .CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(data),
        .ramstate(st[0]), .ramload(ld[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));
    ram_latency_model #(.LAT(0), .ADDR_BITS(10)) u1 (
        .CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(data),
        .ramstate(st[1]), .ramload(ld[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));
    ram_latency_model #(.LAT(3), .ADDR_BITS(10)) u2 (
        .CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(data),
        .ramstate(st[2]), .ramload(ld[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a legal request held unchanged for n prior cycles is in ACCESS when
    // n mod (LAT+1) == LAT, otherwise BUSY. Memory and counters are plain arrays.
    int          lat_of [3] = '{2, 0, 3};
    int          hold;
    logic [31:0] h_addr;
    logic        h_wen;
    logic [31:0] mm [3][1024];
    bit          mk [3][1024];
    logic [31:0] mrd [3];
    logic [31:0] mwr [3];

    function automatic bit m_legal();
        return (ren || wen) && !(ren && wen) && (addr % 4 == 0) && (addr < 32'd4096);
    endfunction

    function automatic int m_phase();
        return (hold > 0 && addr == h_addr && wen == h_wen) ? hold : 0;
    endfunction

    function automatic logic [1:0] m_state(int k);
        if (rst || !(ren || wen)) return FREE;
        if (!m_legal()) return ERROR;
        return ((m_phase() % (lat_of[k] + 1)) == lat_of[k]) ? ACCESS : BUSY;
    endfunction

    task automatic drive(input logic r, input logic re, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        rst = r; ren = re; wen = we; addr = a; data = d;
        #2;
    endtask

    // Advance one clock, applying the cycle's effects to the model
    task automatic tick();
        logic [9:0] w;
        @(posedge clk);
        w = addr[11:2];
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mrd[k] = 0;
                mwr[k] = 0;
            end else if (m_state(k) == ACCESS) begin
                if (wen) begin
                    mm[k][w] = data;
                    mk[k][w] = 1'b1;
                    mwr[k]   = mwr[k] + 1;
                end else begin
                    mrd[k] = mrd[k] + 1;
                end
            end
        end
        if (rst || !m_legal()) begin
            hold = 0;
        end else begin
            hold   = m_phase() + 1;
            h_addr = addr;
            h_wen  = wen;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (st[k] !== FREE || ld[k] !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_out u%0d: state=%0d load=%h want state=0 load=0", k, st[k], ld[k]);
                end
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (st[k] !== FREE || rdc[k] !== 32'd0 || wrc[k] !== 32'd0) begin
                failures++;
                $display("FAIL idle_after_reset u%0d: state=%0d rd=%0d wr=%0d want 0 0 0", k, st[k], rdc[k], wrc[k]);
            end
        end
        tick();
    endtask

    task automatic test_write_read();
        drive(0, 0, 1, 32'h40, 32'hDEADBEEF);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (st[0] !== (c == 2 ? ACCESS : BUSY) || ld[0] !== 32'h0) begin
                failures++;
                $display("FAIL write_seq c%0d: state=%0d load=%h want state=%0d load=0", c, st[0], ld[0], (c == 2 ? ACCESS : BUSY));
            end
            tick();
        end
        checks++;
        if (wrc[0] !== 32'd1) begin
            failures++;
            $display("FAIL write_count: got %0d want 1", wrc[0]);
        end
        drive(0, 1, 0, 32'h40, 32'h0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (st[0] !== (c == 2 ? ACCESS : BUSY) || ld[0] !== (c == 2 ? 32'hDEADBEEF : 32'h0)) begin
                failures++;
                $display("FAIL read_seq c%0d: state=%0d load=%h", c, st[0], ld[0]);
            end
            tick();
        end
        checks++;
        if (rdc[0] !== 32'd1) begin
            failures++;
            $display("FAIL read_count: got %0d want 1", rdc[0]);
        end
    endtask

    task automatic test_addr_change();
        drive(0, 1, 0, 32'h40, 32'h0);
        checks++;
        if (st[0] !== BUSY) begin
            failures++;
            $display("FAIL switch_first: got %0d want %0d", st[0], BUSY);
        end
        tick();
        drive(0, 1, 0, 32'h44, 32'h0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (st[0] !== (c == 2 ? ACCESS : BUSY)) begin
                failures++;
                $display("FAIL switch_seq c%0d: got %0d want %0d", c, st[0], (c == 2 ? ACCESS : BUSY));
            end
            tick();
        end
        checks++;
        if (rdc[0] !== 32'd2) begin
            failures++;
            $display("FAIL switch_count: got %0d want 2", rdc[0]);
        end
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 32'h40, 32'h0);
        tick();
        tick();
        checks++;
        if (st[0] !== ACCESS || ld[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL switch_keep: state=%0d load=%h want %0d deadbeef", st[0], ld[0], ACCESS);
        end
        tick();
        checks++;
        if (rdc[0] !== 32'd3) begin
            failures++;
            $display("FAIL switch_count2: got %0d want 3", rdc[0]);
        end
    endtask

    task automatic test_errors();
        bit          er [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit          ew [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ea [4] = '{32'h0, 32'h42, 32'h1000, 32'h1000};
        drive(0, 0, 1, 32'h0, 32'hCAFEF00D);
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, er[i], ew[i], ea[i], 32'h12345678);
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (st[k] !== ERROR || ld[k] !== 32'h0) begin
                        failures++;
                        $display("FAIL error_p%0d u%0d: state=%0d load=%h want %0d 0", i, k, st[k], ld[k], ERROR);
                    end
                end
                tick();
            end
        end
        checks++;
        if (wrc[0] !== 32'd2 || rdc[0] !== 32'd3) begin
            failures++;
            $display("FAIL error_counts: rd=%0d wr=%0d want 3 2", rdc[0], wrc[0]);
        end
        drive(0, 1, 0, 32'h0, 32'h0);
        tick(); tick();
        checks++;
        if (st[0] !== ACCESS || ld[0] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL error_nowrite: state=%0d load=%h want %0d cafef00d", st[0], ld[0], ACCESS);
        end
        tick();
    endtask

    task automatic test_lat0_stream();
        logic [31:0] v [3];
        drive(1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) v[i] = $urandom;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 32'(i * 4), v[i]);
            checks++;
            if (st[1] !== ACCESS) begin
                failures++;
                $display("FAIL lat0_write i%0d: got %0d want %0d", i, st[1], ACCESS);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 32'(i * 4), 32'h0);
            checks++;
            if (st[1] !== ACCESS || ld[1] !== v[i]) begin
                failures++;
                $display("FAIL lat0_read i%0d: state=%0d load=%h want %0d %h", i, st[1], ld[1], ACCESS, v[i]);
            end
            tick();
        end
        checks++;
        if (rdc[1] !== 32'd3 || wrc[1] !== 32'd3) begin
            failures++;
            $display("FAIL lat0_counts: rd=%0d wr=%0d want 3 3", rdc[1], wrc[1]);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] v;
        v = $urandom;
        drive(0, 0, 1, 32'h80, v);
        tick(); tick(); tick(); tick();
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 32'h80, ~v);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (st[2] !== BUSY) begin
                failures++;
                $display("FAIL midbusy_seq c%0d: got %0d want %0d", c, st[2], BUSY);
            end
            tick();
        end
        drive(1, 0, 1, 32'h80, ~v);
        checks++;
        if (st[2] !== FREE || ld[2] !== 32'h0) begin
            failures++;
            $display("FAIL midbusy_rst: state=%0d load=%h want 0 0", st[2], ld[2]);
        end
        tick();
        drive(0, 1, 0, 32'h80, 32'h0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (st[2] !== (c == 3 ? ACCESS : BUSY) || ld[2] !== (c == 3 ? v : 32'h0)) begin
                failures++;
                $display("FAIL midbusy_read c%0d: state=%0d load=%h want old %h", c, st[2], ld[2], v);
            end
            tick();
        end
        checks++;
        if (wrc[2] !== 32'd0 || rdc[2] !== 32'd1) begin
            failures++;
            $display("FAIL midbusy_counts: rd=%0d wr=%0d want 1 0", rdc[2], wrc[2]);
        end
    endtask

    task automatic test_random();
        int          remain;
        int          sel;
        logic        r_re, r_we;
        logic [31:0] r_a, r_d, want;
        logic [1:0]  es;
        bit          know;
        remain = 0;
        r_re = 0; r_we = 0; r_a = 0; r_d = 0;
        for (int n = 0; n < 400; n++) begin
            if (remain == 0) begin
                sel  = $urandom_range(0, 9);
                r_d  = $urandom;
                r_a  = 32'($urandom_range(0, 15) * 4);
                r_re = 0; r_we = 0;
                case (sel)
                    0: ;
                    1: begin r_re = 1; r_we = 1; end
                    2: begin r_we = 1; r_a = r_a + 32'd2; end
                    3: begin r_re = 1; r_a = r_a + 32'h1000; end
                    default: begin r_we = ($urandom_range(0, 1) == 1); r_re = !r_we; end
                endcase
                remain = $urandom_range(1, 6);
            end
            drive(0, r_re, r_we, r_a, r_d);
            for (int k = 0; k < 3; k++) begin
                es   = m_state(k);
                know = 1'b1;
                want = 32'h0;
                if (es == ACCESS && ren) begin
                    know = mk[k][addr[11:2]];
                    want = mm[k][addr[11:2]];
                end
                checks++;
                if (st[k] !== es || (know && ld[k] !== want)) begin
                    failures++;
                    $display("FAIL rand_out n%0d u%0d: state=%0d load=%h want %0d %h", n, k, st[k], ld[k], es, want);
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rdc[k] !== mrd[k] || wrc[k] !== mwr[k]) begin
                    failures++;
                    $display("FAIL rand_counts n%0d u%0d: rd=%0d wr=%0d want %0d %0d", n, k, rdc[k], wrc[k], mrd[k], mwr[k]);
                end
            end
            remain--;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        hold     = 0;
        h_addr   = 0;
        h_wen    = 0;
        for (int k = 0; k < 3; k++) begin
            mrd[k] = 0;
            mwr[k] = 0;
            for (int i = 0; i < 1024; i++) mk[k][i] = 1'b0;
        end
        rst = 1; ren = 0; wen = 0; addr = 0; data = 0;
        test_reset();
        test_write_read();
        test_addr_change();
        test_errors();
        test_lat0_stream();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_latency_model.md
# ram_latency_model

Word-addressed RAM responder that sits on the RAM side of the coherence/memory controller and answers its ramREN/ramWEN/ramaddr/ramstore requests with ramstate and ramload. It models a configurable access latency (BUSY cycles before ACCESS), flags illegal requests with ERROR and keeps read/write statistics. It is the bench and system memory for single- and dual-core builds.

## Interface
- LAT, 2: BUSY cycles before the ACCESS cycle (0 allowed; 0..15).
- ADDR_BITS, 10: log2 of the number of 32-bit words stored (default 1024 words = 4 KiB).
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- ramREN  input  1  read request from controller.
- ramWEN  input  1  write request from controller.
- ramaddr  input  32 (word_t)  byte address.
- ramstore  input  32 (word_t)  write data.
- ramstate  output  ramstate_t  FREE / BUSY / ACCESS / ERROR.
- ramload  output  32 (word_t)  read data, valid only when ramstate==ACCESS on a read.
- rd_count  output  32  number of completed read ACCESS cycles.
- wr_count  output  32  number of completed write ACCESS cycles.

## Operation
- Control registers: active (1b), cnt (4b), lat_addr (32b), lat_wen (1b); rd_count, wr_count; mem[2**ADDR_BITS] of word_t.
- Illegal request (combinational): ramREN && ramWEN, or ramaddr[1:0]!=0, or ramaddr[31:ADDR_BITS+2]!=0 when a request is present -> ramstate=ERROR, no memory write, active<=0, counters unchanged.
- No request (ramREN==ramWEN==0): ramstate=FREE, active<=0.
- Legal request, new transaction (active==0, or ramaddr!=lat_addr, or ramWEN!=lat_wen): latch lat_addr<=ramaddr, lat_wen<=ramWEN, active<=1, cnt<=1; ramstate=BUSY; if LAT==0, instead treat as ACCESS this cycle (see below).
- Legal request, same transaction, cnt<LAT: ramstate=BUSY, cnt<=cnt+1.
- Legal request, same transaction, cnt==LAT: ramstate=ACCESS; read: ramload=mem[ramaddr[ADDR_BITS+1:2]], rd_count<=rd_count+1; write: mem[index]<=ramstore at this edge, wr_count<=wr_count+1; active<=0.
- Change of address or direction mid-BUSY aborts the old transaction silently and restarts counting; no partial write ever occurs.
- Holding the same request after ACCESS starts a fresh transaction (new LAT BUSY cycles); back-to-back accesses to one word each pay full latency.
- ramload=32'h0 whenever ramstate!=ACCESS or the access is a write.
- Counters wrap modulo 2**32.
- Memory contents are not reset; undefined until written.

## Timing
- ramstate and ramload are combinational from current inputs and registered control state; all updates happen on the rising CLK edge.
- A request held stable from cycle 0 sees BUSY in cycles 0..LAT-1 and ACCESS in cycle LAT (LAT+1 cycles total); with LAT=0, ACCESS in cycle 0.
- Read data is from memory state before that cycle's edge. Memory is single-ported, so a write and a read cannot coincide.
- Reset: while RST is high, ramstate=FREE, ramload=0, no memory write, active=0, cnt=0, lat_addr=0, lat_wen=0, rd_count=wr_count=0. These values are visible in the cycle after the edge.
- Reset asserted mid-BUSY discards the transaction. A request present in the first cycle after RST deasserts starts a new transaction.

## Test plan
- Reset then idle, LAT=2: RST high 2 cycles, inputs 0 -> ramstate FREE, ramload 0, rd_count=wr_count=0.
- Write then read, LAT=2: hold ramWEN, addr 0x40, data 0xDEADBEEF -> BUSY, BUSY, ACCESS; wr_count=1. Then hold ramREN, addr 0x40 -> BUSY, BUSY, ACCESS with ramload 0xDEADBEEF; rd_count=1.
- Address change mid-transaction: ramREN on 0x40 for 1 cycle, then 0x44 -> BUSY count restarts; ACCESS 2 cycles after the switch; word at 0x40 unchanged; rd_count increments once.
- Errors: ramREN&ramWEN, addr 0x42, addr 0x1000 (ADDR_BITS=10) -> ERROR each cycle, no write (a later read of 0x0 returns the prior value), counters unchanged.
- LAT=0 streaming: ramREN held, addr stepping 0x0,0x4,0x8 each cycle -> ACCESS every cycle with the correct data; rd_count=3.
- Reset mid-BUSY, LAT=3: ramWEN to 0x80 for 2 cycles, RST 1 cycle, release -> no write at 0x80 (readback shows the old value); wr_count=0.
